// File: rtl/counting_sort_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | counting_sort_core: histogram-based sorter, asc/desc, saturating bins   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module counting_sort_core #(
  parameter int VALUE_W = 10,
  parameter int LEN_W   = 16,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   start_len,
  input  logic               start_desc,
  input  logic [VALUE_W-1:0] s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [VALUE_W-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy,
  output logic               done,
  output logic               sat_err,
  output logic [LEN_W-1:0]   out_count
);

  localparam int                 c_depth   = 2**VALUE_W;
  localparam logic [VALUE_W-1:0] c_last    = {VALUE_W{1'b1}};
  localparam logic [COUNT_W-1:0] c_cnt_max = {COUNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_LOAD_ACC = 3'd2,
    S_LOAD_WR  = 3'd3,
    S_SCAN     = 3'd4,
    S_SCAN_CHK = 3'd5,
    S_EMIT     = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t             r_state, w_next;
  logic [LEN_W-1:0]   r_len, r_rem, r_out_count;
  logic               r_desc, r_sat;
  logic [VALUE_W-1:0] r_ptr, r_val, r_vmin, r_vmax;
  logic [COUNT_W-1:0] r_cnt, r_rd;
  logic [COUNT_W-1:0] r_mem [c_depth];

  logic               w_we;
  logic [VALUE_W-1:0] w_addr, w_step;
  logic [COUNT_W-1:0] w_wdata;
  logic               w_scan_end, w_last_nonempty, w_rd_sat;
  logic [LEN_W-1:0]   w_oc_inc;

  assign w_scan_end      = r_desc ? (r_ptr == '0) : (r_ptr == c_last);
  // Last bin holding data in scan order; ends the frame early when counts saturated.
  assign w_last_nonempty = (r_ptr == (r_desc ? r_vmin : r_vmax));
  assign w_step          = r_desc ? (r_ptr - VALUE_W'(1)) : (r_ptr + VALUE_W'(1));
  assign w_rd_sat        = (r_rd == c_cnt_max);
  assign w_oc_inc        = r_out_count + LEN_W'(1);

  assign m_tdata   = r_ptr;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign sat_err   = r_sat;
  assign out_count = r_out_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_we     = 1'b0;
    w_addr   = r_ptr;
    w_wdata  = '0;
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    case (r_state)
      S_IDLE:     if (start) w_next = S_CLEAR;
      S_CLEAR: begin
        w_we = 1'b1;
        if (r_ptr == c_last) w_next = (r_len == '0) ? S_DONE : S_LOAD_ACC;
      end
      S_LOAD_ACC: begin
        s_tready = 1'b1;
        w_addr   = s_tdata;
        if (s_tvalid) w_next = S_LOAD_WR;
      end
      S_LOAD_WR: begin
        w_we    = 1'b1;
        w_addr  = r_val;
        w_wdata = w_rd_sat ? r_rd : (r_rd + COUNT_W'(1));
        w_next  = (r_rem == LEN_W'(1)) ? S_SCAN : S_LOAD_ACC;
      end
      S_SCAN:     w_next = S_SCAN_CHK;
      S_SCAN_CHK: begin
        if (r_rd != '0)     w_next = S_EMIT;
        else if (w_scan_end) w_next = S_DONE;
        else                w_next = S_SCAN;
      end
      S_EMIT: begin
        m_tvalid = 1'b1;
        m_tlast  = (w_oc_inc == r_len) || ((r_cnt == COUNT_W'(1)) && w_last_nonempty);
        if (m_tready && (r_cnt == COUNT_W'(1))) w_next = w_scan_end ? S_DONE : S_SCAN;
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Single-port histogram RAM, read-first, one-cycle read latency.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_wdata;
    r_rd <= r_mem[w_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_rem       <= '0;
      r_out_count <= '0;
      r_desc      <= 1'b0;
      r_sat       <= 1'b0;
      r_ptr       <= '0;
      r_val       <= '0;
      r_vmin      <= '0;
      r_vmax      <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_len       <= start_len;
          r_rem       <= start_len;
          r_desc      <= start_desc;
          r_sat       <= 1'b0;
          r_out_count <= '0;
          r_ptr       <= '0;
          r_vmin      <= c_last;
          r_vmax      <= '0;
        end
        S_CLEAR:    r_ptr <= r_ptr + VALUE_W'(1);
        S_LOAD_ACC: if (s_tvalid) begin
          r_val <= s_tdata;
          if (s_tdata < r_vmin) r_vmin <= s_tdata;
          if (s_tdata > r_vmax) r_vmax <= s_tdata;
        end
        S_LOAD_WR: begin
          r_rem <= r_rem - LEN_W'(1);
          if (w_rd_sat) r_sat <= 1'b1;
          if (r_rem == LEN_W'(1)) r_ptr <= r_desc ? c_last : '0;
        end
        S_SCAN_CHK: begin
          if (r_rd != '0)      r_cnt <= r_rd;
          else if (!w_scan_end) r_ptr <= w_step;
        end
        S_EMIT: if (m_tready) begin
          r_cnt       <= r_cnt - COUNT_W'(1);
          r_out_count <= w_oc_inc;
          if ((r_cnt == COUNT_W'(1)) && !w_scan_end) r_ptr <= w_step;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counting_sort_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_counting_sort_core: table, directed and random frames vs. a model    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_counting_sort_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_start, a_desc, a_s_tvalid, a_s_tready, a_m_tvalid, a_m_tlast;
  logic        a_busy, a_done, a_sat;
  logic [15:0] a_len, a_outcnt;
  logic [9:0]  a_s_tdata, a_m_tdata;
  logic        b_start, b_desc, b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tlast;
  logic        b_busy, b_done, b_sat;
  logic [15:0] b_len, b_outcnt;
  logic [3:0]  b_s_tdata, b_m_tdata;
  logic        m_tready;

  counting_sort_core dut_a (
    .clk(clk), .rst(rst), .start(a_start), .start_len(a_len), .start_desc(a_desc),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(m_tready), .m_tlast(a_m_tlast),
    .busy(a_busy), .done(a_done), .sat_err(a_sat), .out_count(a_outcnt));

  counting_sort_core #(.VALUE_W(4), .LEN_W(16), .COUNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .start_len(b_len), .start_desc(b_desc),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(m_tready), .m_tlast(b_m_tlast),
    .busy(b_busy), .done(b_done), .sat_err(b_sat), .out_count(b_outcnt));

  bit sel_b = 1'b0;
  int cur_mdata, cur_outcnt;
  logic cur_s_tready, cur_m_tvalid, cur_m_tlast, cur_done, cur_busy, cur_sat;
  always_comb begin
    cur_mdata    = sel_b ? int'(b_m_tdata)  : int'(a_m_tdata);
    cur_outcnt   = sel_b ? int'(b_outcnt)   : int'(a_outcnt);
    cur_s_tready = sel_b ? b_s_tready : a_s_tready;
    cur_m_tvalid = sel_b ? b_m_tvalid : a_m_tvalid;
    cur_m_tlast  = sel_b ? b_m_tlast  : a_m_tlast;
    cur_done     = sel_b ? b_done     : a_done;
    cur_busy     = sel_b ? b_busy     : a_busy;
    cur_sat      = sel_b ? b_sat      : a_sat;
  end

  int n_checks = 0;
  int n_err    = 0;
  int q_in[$], q_exp[$], q_out[$];
  bit q_last[$];
  int frame_cycles;

  typedef struct packed {
    logic [7:0]       len;
    logic             desc;
    logic [3:0]       n_in;
    logic [7:0][9:0]  vin;
    logic [3:0]       n_exp;
    logic [7:0][9:0]  vexp;
    logic [1:0]       tr;     // 0 always ready, 1 toggle, 2 random
    logic             poke;   // pulse start while emitting
  } vec_t;
  vec_t vecs[7];

  function automatic logic [7:0][9:0] p8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][9:0] r;
    r[0] = 10'(a0); r[1] = 10'(a1); r[2] = 10'(a2); r[3] = 10'(a3);
    r[4] = 10'(a4); r[5] = 10'(a5); r[6] = 10'(a6); r[7] = 10'(a7);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: histogram with clamped bins, walked in the requested direction.
  task automatic model(input int len, input bit desc, input int nbins, input int cmax,
                       output bit sat);
    int hist[];
    hist = new[nbins];
    sat = 1'b0;
    for (int i = 0; i < len; i++) hist[q_in[i]]++;
    q_exp.delete();
    for (int k = 0; k < nbins; k++) begin
      int b = desc ? (nbins - 1 - k) : k;
      if (hist[b] > cmax) begin sat = 1'b1; hist[b] = cmax; end
      for (int n = 0; n < hist[b]; n++) q_exp.push_back(b);
    end
  endtask

  task automatic run_frame(input int len, input bit desc, input int tr_mode,
                           input int abort_after, input bit poke);
    int  idx = 0, cyc = 1, prev_data = 0;
    bit  stalled = 1'b0, poked = 1'b0, fin = 1'b0, v, tog = 1'b1;
    q_out.delete(); q_last.delete(); frame_cycles = -1;
    if (sel_b) begin b_start = 1'b1; b_len = 16'(len); b_desc = desc; end
    else       begin a_start = 1'b1; a_len = 16'(len); a_desc = desc; end
    @(posedge clk); #1;
    while (!fin && cyc < 8000) begin
      a_start = 1'b0; b_start = 1'b0;
      v = (idx < q_in.size());
      if (sel_b) begin b_s_tvalid = v; b_s_tdata = v ? 4'(q_in[idx]) : 4'd0; end
      else       begin a_s_tvalid = v; a_s_tdata = v ? 10'(q_in[idx]) : 10'd0; end
      case (tr_mode)
        0:       m_tready = 1'b1;
        1:       begin m_tready = tog; tog = ~tog; end
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      if (poke && !poked && cur_m_tvalid) begin
        poked = 1'b1;
        if (sel_b) begin b_start = 1'b1; b_len = 16'd1; b_desc = ~desc; end
        else       begin a_start = 1'b1; a_len = 16'd1; a_desc = ~desc; end
      end
      #1;
      if (stalled) begin
        chk("stall_data", cur_mdata, prev_data);
        chk("stall_valid", int'(cur_m_tvalid), 1);
      end
      stalled   = cur_m_tvalid && !m_tready;
      prev_data = cur_mdata;
      if (cur_done) begin
        frame_cycles = cyc;
        fin = 1'b1;
      end else begin
        if (cur_s_tready && v) idx++;
        if (cur_m_tvalid && m_tready) begin
          q_out.push_back(cur_mdata);
          q_last.push_back(cur_m_tlast);
          if (abort_after != 0 && q_out.size() == abort_after) begin
            @(posedge clk); #1;
            a_start = 1'b0; b_start = 1'b0;
            return;
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    a_start = 1'b0; b_start = 1'b0; a_s_tvalid = 1'b0; b_s_tvalid = 1'b0; m_tready = 1'b1;
    if (!fin) begin
      n_checks++; n_err++;
      $display("FAIL frame_timeout: no done after %0d cycles", cyc);
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_beats"}, q_out.size(), q_exp.size());
    for (int j = 0; j < q_out.size() && j < q_exp.size(); j++) begin
      chk($sformatf("%s_data%0d", tag, j), q_out[j], q_exp[j]);
      chk($sformatf("%s_last%0d", tag, j), int'(q_last[j]), (j == q_exp.size() - 1) ? 1 : 0);
    end
    chk({tag, "_out_count"}, cur_outcnt, q_exp.size());
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sat;
    int len;
    a_start = 0; a_desc = 0; a_len = 0; a_s_tdata = 0; a_s_tvalid = 0;
    b_start = 0; b_desc = 0; b_len = 0; b_s_tdata = 0; b_s_tvalid = 0;
    m_tready = 1;
    vecs[0] = '{8'd6, 1'b0, 4'd6, p8(5,2,5,1,5,2,0,0),        4'd6, p8(1,2,2,5,5,5,0,0),        2'd0, 1'b0};
    vecs[1] = '{8'd6, 1'b1, 4'd6, p8(5,2,5,1,5,2,0,0),        4'd6, p8(5,5,5,2,2,1,0,0),        2'd0, 1'b0};
    vecs[2] = '{8'd4, 1'b1, 4'd4, p8(1023,0,511,256,0,0,0,0), 4'd4, p8(1023,511,256,0,0,0,0,0), 2'd0, 1'b0};
    vecs[3] = '{8'd0, 1'b0, 4'd0, p8(0,0,0,0,0,0,0,0),        4'd0, p8(0,0,0,0,0,0,0,0),        2'd0, 1'b0};
    vecs[4] = '{8'd1, 1'b0, 4'd1, p8(42,0,0,0,0,0,0,0),       4'd1, p8(42,0,0,0,0,0,0,0),       2'd0, 1'b0};
    vecs[5] = '{8'd3, 1'b0, 4'd3, p8(100,100,100,0,0,0,0,0),  4'd3, p8(100,100,100,0,0,0,0,0),  2'd1, 1'b1};
    vecs[6] = '{8'd2, 1'b0, 4'd3, p8(9,3,7,0,0,0,0,0),        4'd2, p8(3,9,0,0,0,0,0,0),        2'd2, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", int'(a_s_tready), 0);
    chk("rst_m_tvalid", int'(a_m_tvalid), 0);
    chk("rst_busy",     int'(a_busy), 0);
    chk("rst_done",     int'(a_done), 0);
    chk("rst_sat",      int'(a_sat), 0);
    chk("rst_outcnt",   int'(a_outcnt), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      sel_b = 1'b0;
      q_in.delete();
      for (int j = 0; j < vecs[i].n_in; j++) q_in.push_back(int'(vecs[i].vin[j]));
      run_frame(int'(vecs[i].len), vecs[i].desc, int'(vecs[i].tr), 0, vecs[i].poke);
      q_exp.delete();
      for (int j = 0; j < vecs[i].n_exp; j++) q_exp.push_back(int'(vecs[i].vexp[j]));
      check_frame($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_sat", i), int'(cur_sat), 0);
      if (vecs[i].len == 8'd0) chk("len0_latency", int'(frame_cycles <= 1028), 1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_idle", i), int'(cur_busy), 0);
    end

    // Saturating bins on the narrow instance, both directions.
    sel_b = 1'b1;
    q_in = '{7, 7, 7, 7, 3};
    run_frame(5, 1'b0, 0, 0, 1'b0);
    q_exp = '{3, 7, 7, 7};
    check_frame("sat_asc");
    chk("sat_asc_flag", int'(cur_sat), 1);
    @(posedge clk); #1;
    run_frame(5, 1'b1, 1, 0, 1'b0);
    q_exp = '{7, 7, 7, 3};
    check_frame("sat_desc");
    chk("sat_desc_flag", int'(cur_sat), 1);
    @(posedge clk); #1;

    // Reset in the middle of emission, then a fresh frame.
    sel_b = 1'b0;
    q_in = '{4, 3, 2, 1};
    run_frame(4, 1'b0, 0, 2, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_tvalid", int'(a_m_tvalid), 0);
    chk("mid_rst_m_tlast",  int'(a_m_tlast), 0);
    chk("mid_rst_m_tdata",  int'(a_m_tdata), 0);
    chk("mid_rst_busy",     int'(a_busy), 0);
    chk("mid_rst_outcnt",   int'(a_outcnt), 0);
    chk("mid_rst_s_tready", int'(a_s_tready), 0);
    a_s_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    q_in = '{9, 8, 7};
    run_frame(3, 1'b0, 0, 0, 1'b0);
    q_exp = '{7, 8, 9};
    check_frame("post_rst");
    @(posedge clk); #1;

    // Random frames against the reference model.
    for (int r = 0; r < 5; r++) begin
      bit dsc, narrow;
      len    = int'($urandom_range(1, 40));
      dsc    = 1'($urandom_range(0, 1));
      narrow = 1'($urandom_range(0, 1));
      q_in.delete();
      for (int j = 0; j < len; j++)
        q_in.push_back(narrow ? int'($urandom_range(500, 507)) : int'($urandom_range(0, 1023)));
      run_frame(len, dsc, 2, 0, 1'b0);
      model(len, dsc, 1024, 65535, sat);
      check_frame($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_sat", r), int'(cur_sat), int'(sat));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counting_sort_core.md
Name: counting_sort_core

Overview:
- Parametrised counting-sort engine that sits between the UART framing logic and the host-facing byte packer in the FPGA sorting design.
- Accepts a declared-length frame of unsigned values on an AXI-Stream-style input and builds a histogram in on-chip RAM.
- Emits the values sorted, in ascending or descending order, on an AXI-Stream-style output with tlast.
- Generalises the fixed 10-bit ascending-only sorter: value width, length width and bin-counter width are parameters; direction is selected per frame; bin-counter saturation is detected and reported.

Parameters:
- VALUE_W, 10, value width in bits; histogram has 2**VALUE_W bins.
- LEN_W, 16, width of the frame length.
- COUNT_W, 16, width of each histogram bin counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a frame. Sampled only in IDLE.
- start_len  in  LEN_W  number of values in the frame; latched on an accepted start.
- start_desc  in  1  1 = descending output, 0 = ascending; latched on an accepted start.
- s_tdata  in  VALUE_W  input value.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_tdata  out  VALUE_W  sorted output value.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  asserted with the final output value of the frame.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.
- sat_err  out  1  sticky flag: a bin counter saturated during the current frame; cleared on the next accepted start.
- out_count  out  LEN_W  number of values emitted in the current frame; cleared on an accepted start.

Behaviour:
- Reset (async): state IDLE; s_tready, m_tvalid, m_tlast, busy, done, sat_err = 0; out_count = 0; m_tdata = 0. RAM contents are undefined after reset; the CLEAR state makes this harmless.
- Histogram RAM: 2**VALUE_W x COUNT_W, synchronous read with 1-cycle latency, single port.
- IDLE:
  - start=1 latches len and desc, clears sat_err and out_count, then goes to CLEAR.
  - While busy, start is ignored entirely; latched values do not change.
- CLEAR: writes 0 to bins 0..2**VALUE_W-1, one per cycle (exactly 2**VALUE_W cycles). If len==0, go to DONE; otherwise go to LOAD_ACC.
- LOAD_ACC: s_tready=1.
  - On s_tvalid&&s_tready: capture the value, issue a RAM read, go to LOAD_WR.
  - Throughput is one value per 2 cycles.
- LOAD_WR: s_tready=0.
  - Write count+1 to the bin; if count is already all-ones, write it back unchanged and set sat_err.
  - Decrement remaining; if it reaches 0, go to SCAN, else go back to LOAD_ACC.
  - Extra s_tvalid beats after len values are not consumed in this frame.
- SCAN:
  - Bin pointer starts at 0 (asc) or 2**VALUE_W-1 (desc).
  - Read the bin. If count==0, step the pointer; each empty bin costs at most 2 cycles.
  - If count>0, go to EMIT with that count.
  - After the last bin is examined (2**VALUE_W-1 for asc, 0 for desc), go to DONE. The pointer never wraps.
- EMIT:
  - m_tvalid=1, m_tdata = bin index.
  - On each m_tvalid&&m_tready: decrement count and increment out_count.
  - m_tlast=1 on the beat where out_count+1 == len. On a saturated frame where fewer values will be emitted, m_tlast is instead on the beat that empties the last non-empty bin.
  - m_tdata and m_tvalid stay stable while m_tready=0.
  - When count reaches 0, go back to SCAN, or go to DONE if this was the last bin.
- DONE: done=1 for one cycle, then go to IDLE. Zero-length frames produce done with no m_tvalid.
- Reset asserted mid-frame returns to IDLE immediately. The next frame is correct because CLEAR runs first.
- Simultaneous start and an input beat in IDLE: the beat is not accepted, since s_tready=0 in IDLE.

Test Plan:
- Ascending, defaults: start_len=6, desc=0, inputs 5,2,5,1,5,2 -> outputs 1,2,2,5,5,5; tlast only on the 6th beat; done pulse; out_count=6; sat_err=0.
- Descending: same inputs with desc=1 -> outputs 5,5,5,2,2,1; tlast on the 6th beat. Also inputs 1023,0,511,256 -> outputs 1023,511,256,0.
- Empty and single frames: len=0 -> no m_tvalid, done within 2**VALUE_W+4 cycles of start. Then len=1 with value 42 -> single beat 42 with tlast.
- Backpressure and ignored start: len=3, inputs 100,100,100; m_tready toggles 1-0-1-0 -> exactly three beats of 100 with stable data while stalled. A start pulse during EMIT has no effect.
- Saturation, COUNT_W=2 and VALUE_W=4: len=5, inputs 7,7,7,7,3 -> sat_err=1; outputs 3,7,7,7 with tlast on the 4th beat; out_count=4.
- Reset mid-frame: assert rst after 2 of 4 beats are emitted -> all outputs return to reset values. A fresh len=3 frame with 9,8,7 -> outputs 7,8,9 with no stale bins.
